// File: rtl/expr_gen.sv
// expr_gen: emits a captured "digit (op digit)*" expression as ASCII, one character per valid/ready transfer.
// Optional trailing '=' character is built when EXPR_GEN_EQ_EN is defined.
module expr_gen #(
    parameter int MAX_TERMS = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic [3:0]               term_cnt,
    input  logic [4*MAX_TERMS-1:0]   digits,
    input  logic [MAX_TERMS-2:0]     ops,
    input  logic                     ready,
    output logic [7:0]               out,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIG  = 3'd1,
        ST_OP   = 3'd2,
`ifdef EXPR_GEN_EQ_EN
        ST_EQ   = 3'd4,
`endif
        ST_FIN  = 3'd3
    } state_t;

    localparam logic [3:0] MAX_N = 4'(MAX_TERMS);
`ifdef EXPR_GEN_EQ_EN
    localparam state_t LAST_NXT = ST_EQ;
`else
    localparam state_t LAST_NXT = ST_FIN;
`endif

    state_t                   state_r, state_nxt_s;
    logic [3:0]               k_r, k_nxt_s;
    logic [3:0]               n_r, n_cap_s;
    logic [4*MAX_TERMS-1:0]   digits_r, dig_src_s;
    logic [MAX_TERMS-2:0]     ops_r, op_src_s;
    logic [3:0]               dig_val_s;
    logic                     op_val_s;
    logic                     accept_s;
    logic [7:0]               out_r, out_nxt_s;
    logic                     valid_r, valid_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     done_r, done_nxt_s;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        if (d > 4'd9) begin
            digit_char = 8'h39;
        end else begin
            digit_char = 8'h30 + {4'h0, d};
        end
    endfunction

    function automatic logic [7:0] op_char(input logic o);
        op_char = o ? 8'h2A : 8'h2B;
    endfunction

    assign accept_s = valid_r & ready;
    assign n_cap_s  = (term_cnt > MAX_N) ? MAX_N : term_cnt;

    // State, term index and captured operands; capture only on a start seen in IDLE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            k_r      <= 4'd0;
            n_r      <= 4'd0;
            digits_r <= '0;
            ops_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            if (state_r == ST_IDLE && start) begin
                n_r      <= n_cap_s;
                digits_r <= digits;
                ops_r    <= ops;
            end else begin
                n_r      <= n_r;
                digits_r <= digits_r;
                ops_r    <= ops_r;
            end
        end
    end

    // Next-state and next term index.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    k_nxt_s     = 4'd0;
                    state_nxt_s = (n_cap_s == 4'd0) ? ST_FIN : ST_DIG;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIG: begin
                if (accept_s) begin
                    state_nxt_s = (k_r == n_r - 4'd1) ? LAST_NXT : ST_OP;
                end else begin
                    state_nxt_s = ST_DIG;
                end
            end
            ST_OP: begin
                if (accept_s) begin
                    k_nxt_s     = k_r + 4'd1;
                    state_nxt_s = ST_DIG;
                end else begin
                    state_nxt_s = ST_OP;
                end
            end
`ifdef EXPR_GEN_EQ_EN
            ST_EQ: begin
                if (accept_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_EQ;
                end
            end
`endif
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: begin
                state_nxt_s = ST_IDLE;
                k_nxt_s     = 4'd0;
            end
        endcase
    end

    // Outputs for the coming cycle, decoded from the next state so they can be registered.
    // On the capture edge the operands come straight from the inputs.
    always_comb begin
        dig_src_s   = (state_r == ST_IDLE) ? digits : digits_r;
        op_src_s    = (state_r == ST_IDLE) ? ops : ops_r;
        dig_val_s   = 4'd0;
        op_val_s    = 1'b0;
        out_nxt_s   = 8'h00;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            dig_val_s = (k_nxt_s == 4'(i)) ? dig_src_s[4*i +: 4] : dig_val_s;
        end
        for (int i = 0; i < MAX_TERMS - 1; i++) begin
            op_val_s = (k_nxt_s == 4'(i)) ? op_src_s[i] : op_val_s;
        end
        case (state_nxt_s)
            ST_DIG: begin
                out_nxt_s   = digit_char(dig_val_s);
                valid_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
            ST_OP: begin
                out_nxt_s   = op_char(op_val_s);
                valid_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
`ifdef EXPR_GEN_EQ_EN
            ST_EQ: begin
                out_nxt_s   = 8'h3D;
                valid_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
`endif
            ST_FIN:  done_nxt_s = 1'b1;
            default: done_nxt_s = 1'b0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            out_r   <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            out_r   <= out_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign out   = out_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_expr_gen.sv
// Scoreboard bench for expr_gen: stimulus pushes the expected character stream, a negedge monitor pops and compares.
module tb_expr_gen;
    localparam int MT       = 8;
    localparam int DONE_TOK = 256;

    logic              clk = 1'b0;
    logic              clr, start, ready;
    logic [3:0]        term_cnt;
    logic [4*MT-1:0]   digits;
    logic [MT-2:0]     ops;
    logic [7:0]        out;
    logic              valid, busy, done;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit hold_prev = 1'b0;
    logic [7:0] hold_out = 8'h00;

    always #5 clk = ~clk;

    expr_gen #(.MAX_TERMS(MT)) dut (
        .clk(clk), .clr(clr), .start(start), .term_cnt(term_cnt),
        .digits(digits), .ops(ops), .ready(ready),
        .out(out), .valid(valid), .busy(busy), .done(done)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: expression text from the rules, operands clamped and saturated.
    function automatic int push_model(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
        int nc, len, dv;
        nc = (n > MT) ? MT : n;
        len = 0;
        for (int i = 0; i < nc; i++) begin
            dv = int'((d >> (4 * i)) & 32'hF);
            exp_q.push_back(48 + ((dv > 9) ? 9 : dv));
            len++;
            if (i < nc - 1) begin
                exp_q.push_back(((o >> i) & 7'h1) != 0 ? 42 : 43);
                len++;
            end
        end
`ifdef EXPR_GEN_EQ_EN
        if (nc > 0) begin
            exp_q.push_back(61);
            len++;
        end
`endif
        exp_q.push_back(DONE_TOK);
        return len;
    endfunction

    // Monitor: pops on each accepted character and on each done pulse.
    always @(negedge clk) begin
        if (!clr) begin
            if (hold_prev) begin
                check("hold_valid", int'(valid), 1);
                check("hold_out", int'(out), int'(hold_out));
            end
            if (valid) begin
                check("busy_with_valid", int'(busy), 1);
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_char: got %0h with nothing expected", out);
                    end else begin
                        check("char", int'(out), exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_out_zero", int'(out), 0);
            end
            if (done) begin
                check("busy_during_done", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_done: got done with nothing expected");
                end else begin
                    check("done_order", DONE_TOK, exp_q.pop_front());
                end
            end
            hold_prev = valid && !ready;
            hold_out  = out;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // mode 0: ready high; 1: random ready plus scrambled inputs/start; 2: ready low in cycles 2..4.
    task automatic run_expr(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o, input int mode);
        int len, c, vcount, stall;
        bit got_done;
        len = push_model(n, d, o);
        stall = (mode == 2 && len >= 2) ? 3 : 0;
        term_cnt = 4'(n); digits = d; ops = o; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; vcount = 0; got_done = 1'b0;
        while (c <= 200) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (valid) vcount++;
            if (mode == 1) begin
                ready    = ($urandom_range(0, 3) != 0);
                start    = 1'($urandom_range(0, 1));
                term_cnt = 4'($urandom);
                digits   = $urandom;
                ops      = 7'($urandom);
            end else if (mode == 2) begin
                ready = !(c >= 2 && c <= 4);
            end else begin
                ready = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done after %0d cycles", c);
            exp_q.delete();
        end else if (mode != 1) begin
            check("done_cycle", c, len + 1 + stall);
            check("valid_cycles", vcount, len + stall);
        end
        // start during FIN must be ignored
        start = (mode == 1); term_cnt = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_fin_valid", int'(valid), 0);
        check("post_fin_busy", int'(busy), 0);
        check("post_fin_done", int'(done), 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_clr_abort();
        int len;
        len = push_model(3, 32'h00000321, 7'b0000010);
        term_cnt = 4'd3; digits = 32'h00000321; ops = 7'b0000010; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_clr_out", int'(out), 8'h32);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_q.delete();
        check("clr_out", int'(out), 0);
        check("clr_valid", int'(valid), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_done", int'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_done_after_clr", int'(done), 0);
        end
        check("clr_len", len, 5);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; ready = 1'b0;
        term_cnt = 4'd0; digits = '0; ops = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_out", int'(out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        clr = 1'b0;
        @(posedge clk); #1;

        run_expr(3, 32'h00000321, 7'b0000010, 0);
        run_expr(3, 32'h00000321, 7'b0000010, 2);
        run_expr(1, 32'h0000000C, 7'b0000000, 0);
        run_expr(0, 32'h00000321, 7'b0000010, 0);
        run_clr_abort();
        run_expr(3, 32'h00000987, 7'b0000001, 0);
        run_expr(2, 32'h00000054, 7'b0000001, 0);
        run_expr(8, 32'hFEDCBA98, 7'b1010101, 0);
        run_expr(15, 32'h12345678, 7'b0110011, 0);
        for (int i = 0; i < 40; i++) begin
            run_expr(int'($urandom_range(0, 15)), $urandom, 7'($urandom), 1);
        end
        for (int i = 0; i < 10; i++) begin
            run_expr(int'($urandom_range(0, 15)), $urandom, 7'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/expr_gen.md
# expr_gen

Serial expression generator: the transmitter side of the `expr` character-stream recognizer. On `start` it captures up to `MAX_TERMS` single-digit operands and the operators between them, then emits the expression one 8-bit ASCII character per accepted transfer, using a valid/ready handshake. The output stream is always a well-formed `digit (op digit)*` string, so it can drive an `expr` instance's `in` port directly in self-checking benches.

## Interface
- `MAX_TERMS`, default 8: maximum number of operands per expression (2..15).
- `clk` input 1: clock; all state updates on the rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `start` input 1: request to begin a new expression; sampled only in IDLE.
- `term_cnt` input 4: number of operands N to emit.
- `digits` input 4*MAX_TERMS: operand values; term i is `digits[4i+3:4i]`, term 0 is emitted first.
- `ops` input MAX_TERMS-1: operator i sits between term i and term i+1; 0 = '+' (0x2B), 1 = '*' (0x2A).
- `ready` input 1: downstream accepts the current character this cycle.
- `out` output 8: ASCII character; 0x00 whenever `valid`=0.
- `valid` output 1: `out` holds a character.
- `busy` output 1: expression in progress (start to final accept).
- `done` output 1: one-cycle pulse after the final character is accepted.

## Operation
- FSM states: IDLE, DIG, OP, (EQ if configured), FIN.
- IDLE: `valid`=0, `busy`=0. On `start`=1, register `term_cnt`, `digits`, `ops`; clear term index k=0; go to DIG.
- N rules at capture: N=0 → go straight to FIN (no characters); N>MAX_TERMS → clamp to MAX_TERMS.
- DIG: `out` = 0x30 + term k; term values 10..15 saturate to '9' (0x39). On accept (`valid`&`ready`): if k=N-1 go to EQ/FIN, else go to OP.
- OP: `out` = operator k; on accept, k←k+1, go to DIG.
- FIN: `done`=1 for exactly this cycle, `busy`=0, return to IDLE.
- Emitted length: 2N-1 characters (+1 with `EXPR_GEN_EQ_EN`).
- Captured inputs are frozen for the whole expression; changes on `digits`/`ops`/`term_cnt` after the capture edge have no effect.
- `start` while not in IDLE (including FIN) is ignored; no queuing.

## Timing
- Reset: on an edge with `clr`=1 → IDLE, k=0, `out`=0x00, `valid`=0, `busy`=0, `done`=0. Takes priority over `start` and `ready`; mid-expression clr aborts with no `done` pulse.
- `start` sampled at edge T → `valid`=1, `busy`=1 with first character from T+1.
- Handshake: a character is held stable while `valid`=1 and `ready`=0; next character appears the cycle after an accepting edge. `valid` never drops mid-expression.
- With `ready` held high: one character per cycle, back-to-back; first char at T+1, last at T+2N-1, `done` at T+2N.
- N=0: `done` at T+1, `valid` never asserted.
- Earliest next `start` is sampled in the cycle after `done` (IDLE).
- `busy`=1 from T+1 through the last character's cycle inclusive; `busy`=0 during `done`.

## Configuration
- `EXPR_GEN_EQ_EN` defined: state EQ emits '=' (0x3D) after the last digit, handshaked like any other character. Length becomes 2N; `done` moves one accept later. N=0 still emits nothing.
- Undefined: EQ is not built; DIG on the last term goes directly to FIN.

## Test plan
- N=3, digits {1,2,3}, ops {+,*}, `ready`=1 → `out` 0x31,0x2B,0x32,0x2A,0x33 on T+1..T+5; `done` at T+6 only; `busy` low at T+6.
- Same stimulus, `ready` low for 3 cycles while 0x2B is shown → 0x2B held stable for 4 cycles, no character lost or repeated; `done` at T+9.
- N=1, digit 12 → single char 0x39 at T+1, `done` at T+2; N=0 → `done` at T+1, `valid` stays 0.
- `clr`=1 while 0x32 is presented → next cycle `out`=0x00, `valid`=0, `busy`=0, no `done`; a fresh `start` then generates a full expression correctly.
- `start` pulsed during busy and during FIN, and `digits` changed mid-expression → ignored; stream matches originally captured values.
- With `EXPR_GEN_EQ_EN`, N=2, digits {4,5}, op {*}, `ready`=1 → 0x34,0x2A,0x35,0x3D on T+1..T+4; `done` at T+5.
